pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_pkg.sv | 12 +
 rtl/pixel_writer_if.sv | 25 ++
 rtl/pw_fifo.sv | 33 +++
 rtl/pixel_writer.sv | 74 +++++++
 4 files changed

// File: rtl/pixel_writer_pkg.sv
// pixel_writer_pkg: framebuffer geometry, pixel/coordinate types and word mapping shared by writer and display feeder.
package pixel_writer_pkg;
  localparam int FB_W = 64;
  localparam int FB_H = 48;
  typedef logic [3:0] pixel_t;
  typedef logic [5:0] coord_t;
  typedef enum logic [1:0] {STREAM, DRAIN, CLEAR} state_e;
  // Eight pixels per word: addr={y,x[5:3]}, pix_sel=x[2:0].
  function automatic logic [11:0] fb_word(coord_t y, coord_t x);
    return {y, x};
  endfunction
endpackage

// File: rtl/pixel_writer_if.sv
// pixel_writer_if: pixel stream, memory write port and clear control of the pixel writer.
interface pixel_writer_if;
  import pixel_writer_pkg::*;
  logic in_valid;
  logic in_ready;
  pixel_t in_pixel;
  logic in_sof;
  logic mem_read;
  logic mem_we;
  logic [8:0] addr;
  logic [2:0] pix_sel;
  pixel_t pixel_wr;
  logic frame_done;
  logic clear_req;
  pixel_t clear_color;
  logic busy;
  modport master (
    output in_valid, in_pixel, in_sof, mem_read, clear_req, clear_color,
    input in_ready, mem_we, addr, pix_sel, pixel_wr, frame_done, busy
  );
  modport slave (
    input in_valid, in_pixel, in_sof, mem_read, clear_req, clear_color,
    output in_ready, mem_we, addr, pix_sel, pixel_wr, frame_done, busy
  );
endinterface

// File: rtl/pw_fifo.sv
// pw_fifo: synchronous FIFO with head visible on data_o while non-empty.
module pw_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic [W-1:0] data_i,
  input logic pop_i,
  output logic [W-1:0] data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: buffers streamed pixels into framebuffer writes; PIXEL_WRITER_CLEAR_EN adds drain-then-clear of the whole frame.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk_25,
  input logic rst,
  pixel_writer_if.slave pw
);
  state_e state_q, state_d;
  coord_t x_q, x_d, y_q, y_d, cx, cy;
  pixel_t clr_q, clr_d;
  logic frame_done_q, frame_done_d;
  logic push, pop, full, empty, wr_en, in_clear, adv, x_end, at_end, go_clear;
  logic [15:0] head, wr_ent;
  pw_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk(clk_25),
    .rst(rst),
    .push_i(push),
    .data_i({cy, cx, pw.in_pixel}),
    .pop_i(pop),
    .data_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  // x_q/y_q double as the raster counter during a clear, so a finished clear leaves the stream at (0,0).
  always_comb begin
    in_clear = state_q == CLEAR;
    go_clear = state_q == DRAIN && empty;
    pw.in_ready = !rst && !full && state_q == STREAM;
    push = pw.in_valid && pw.in_ready;
    wr_en = !rst && !pw.mem_read && (in_clear || !empty);
    pop = wr_en && !in_clear;
    wr_ent = in_clear ? {y_q, x_q, clr_q} : head;
    pw.mem_we = wr_en;
    {pw.addr, pw.pix_sel} = wr_en ? fb_word(wr_ent[15:10], wr_ent[9:4]) : '0;
    pw.pixel_wr = wr_en ? wr_ent[3:0] : '0;
    pw.busy = !rst && (!empty || state_q != STREAM);
    pw.frame_done = !rst && frame_done_q;
    cx = pw.in_sof && !in_clear ? '0 : x_q;
    cy = pw.in_sof && !in_clear ? '0 : y_q;
    adv = in_clear ? wr_en : push;
    x_end = cx == coord_t'(FB_W - 1);
    at_end = x_end && cy == coord_t'(FB_H - 1);
    x_d = go_clear ? '0 : adv ? (x_end ? '0 : cx + 1'b1) : x_q;
    y_d = go_clear ? '0 : adv ? (at_end ? '0 : x_end ? cy + 1'b1 : cy) : y_q;
    frame_done_d = push && at_end;
`ifdef PIXEL_WRITER_CLEAR_EN
    state_d = state_q == STREAM && pw.clear_req ? DRAIN :
              go_clear ? CLEAR :
              in_clear && wr_en && at_end ? STREAM : state_q;
    clr_d = state_q == STREAM && pw.clear_req ? pw.clear_color : clr_q;
`else
    state_d = STREAM;
    clr_d = '0;
`endif
  end
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q <= STREAM;
      x_q <= '0;
      y_q <= '0;
      clr_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      clr_q <= clr_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule
